// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one client at a time access to a shared server bus.
// Grant one cycle after request; cl_ack one cycle after srv_ack; transfers time out after TIMEOUT cycles.
module bus_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            cl_rq,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
    input  logic [NUM_CLIENTS-1:0]            cl_wr_ni,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataW,
    output logic [NUM_CLIENTS-1:0]            cl_ack,
    output logic [DATA_WIDTH-1:0]             cl_dataR,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic                              srv_rq,
    output logic [ADDR_WIDTH-1:0]             srv_addr,
    output logic                              srv_wr_ni,
    output logic [DATA_WIDTH-1:0]             srv_dataW,
    input  logic                              srv_ack,
    input  logic [DATA_WIDTH-1:0]             srv_dataR,
    output logic                              timeout_err
);
    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
    logic                  terr_q, terr_d;

    logic [ADDR_WIDTH-1:0]    addr_a  [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0]    dataw_a [NUM_CLIENTS];
    logic [2*NUM_CLIENTS-1:0] rq_dbl;
    logic [NUM_CLIENTS-1:0]   rq_rot;
    logic [NUM_CLIENTS-1:0]   idx_oh;
    logic [IW-1:0]            sel_idx;
    logic [IW-1:0]            ptr_inc;
    logic                     busy;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign addr_a[g]  = cl_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign dataw_a[g] = cl_dataW[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Rotating the requests by ptr turns the search into lowest-set-bit of rq_rot.
    assign rq_dbl = {cl_rq, cl_rq} >> ptr_q;
    assign rq_rot = rq_dbl[NUM_CLIENTS-1:0];

    always_comb begin
        logic [IW:0] cand;
        cand    = '0;
        sel_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (rq_rot[i]) begin
                cand = {1'b0, ptr_q} + (IW+1)'(i);
                if (cand >= (IW+1)'(NUM_CLIENTS)) begin
                    cand = cand - (IW+1)'(NUM_CLIENTS);
                end
                sel_idx = cand[IW-1:0];
            end
        end
    end

    assign ptr_inc = (idx_q == IW'(NUM_CLIENTS - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q;
        data_r_d = data_r_q;
        terr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|cl_rq) begin
                    idx_d   = sel_idx;
                    tcnt_d  = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (srv_ack) begin
                    data_r_d = srv_dataR;
                    state_d  = S_DONE;
                end else if (tcnt_q == TCNT_LAST) begin
                    ptr_d   = ptr_inc;
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = ptr_inc;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            tcnt_q   <= '0;
            data_r_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            data_r_q <= data_r_d;
            terr_q   <= terr_d;
        end
    end

    assign busy        = (state_q == S_BUSY);
    assign idx_oh      = NUM_CLIENTS'(1) << idx_q;
    assign grant       = (busy || state_q == S_DONE) ? idx_oh : '0;
    assign cl_ack      = (state_q == S_DONE) ? idx_oh : '0;
    assign srv_rq      = busy;
    assign srv_addr    = busy ? addr_a[idx_q] : '0;
    assign srv_dataW   = busy ? dataw_a[idx_q] : '0;
    assign srv_wr_ni   = busy ? cl_wr_ni[idx_q] : 1'b1;
    assign cl_dataR    = data_r_q;
    assign timeout_err = terr_q;
endmodule
